vram_write_arbiter: RTL and testbench
=====================================

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter FILL_CHAR, 8'h20: byte written to every VRAM cell during boot fill.
REQ-002 SHALL have parameter BOOT_PATTERN, 0: 0 = boot fill uses FILL_CHAR; 1 = boot fill uses address[7:0].
REQ-003 SHALL have port MEMORY_CLK, input, 1: sole clock; all logic rises on its posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_req, input, 1: CPU write request level, synchronous to MEMORY_CLK.
REQ-006 SHALL have port cpu_ad, input, 10: CPU write address.
REQ-007 SHALL have port cpu_din, input, 8: CPU write data.
REQ-008 SHALL have port cpu_ack, output, 1: CPU write completed; four-phase acknowledge.
REQ-009 SHALL have port clear_req, input, 1: single-cycle pulse requesting a full-screen clear.
REQ-010 SHALL have port clear_char, input, 8: clear byte, sampled on the clear_req cycle.
REQ-011 SHALL have port v_cea, output, 1: VRAM port-A write enable.
REQ-012 SHALL have port v_ada, output, 10: VRAM port-A address.
REQ-013 SHALL have port v_din, output, 8: VRAM port-A write data.
REQ-014 SHALL have port v_reseta, output, 1: VRAM port-A reset; constant 0.
REQ-015 SHALL have port busy, output, 1: high in BOOT and CLEAR.
REQ-016 SHALL have port boot_done, output, 1: high once the boot fill has completed.

Function
REQ-017 SHALL implement the states BOOT, IDLE, CPU_WR, CPU_WAIT and CLEAR.
REQ-018 SHALL register all outputs; each VRAM write is exactly one cycle with v_cea=1 and v_ada/v_din valid in that cycle.
REQ-019 SHALL, in BOOT, write addresses 0..1023 on consecutive cycles (1024 cycles total), using data per BOOT_PATTERN.
REQ-020 SHALL go BOOT -> IDLE after address 1023, with boot_done=1 from the cycle after the last write.
REQ-021 SHALL arbitrate in IDLE with CPU first: cpu_req=1 -> CPU_WR; otherwise a pending clear -> CLEAR.
REQ-022 SHALL, in CPU_WR, write cpu_ad/cpu_din in one cycle, then go to CPU_WAIT with cpu_ack=1.
REQ-023 SHALL hold cpu_ack=1 in CPU_WAIT until cpu_req=0, then clear cpu_ack and return to IDLE; a held-high req never causes a second write.
REQ-024 SHALL, in CLEAR, write clear_char to addresses 0..1023 in 1024 consecutive cycles, then go to IDLE.
REQ-025 SHALL hold cpu_req stalled (no ack) during BOOT and CLEAR and service it in IDLE afterwards.
REQ-026 SHALL latch clear_req arriving in BOOT, CPU_WR or CPU_WAIT as pending together with its clear_char; a later pulse before service overwrites the pending char.
REQ-027 SHALL ignore clear_req arriving in CLEAR.
REQ-028 SHALL, when cpu_req and a pending clear coincide in IDLE, perform the CPU write first and then CLEAR.
REQ-029 SHALL use a 10-bit address counter wrapping 1023 -> 0, with the terminal count detected at 1023.
REQ-030 SHALL hold v_cea=0 in IDLE and CPU_WAIT, with v_ada/v_din holding their last values.

Reset
REQ-031 SHALL, on rst_n low, immediately force: state=BOOT, counter=0, v_cea=0, v_ada=0, v_din=0, v_reseta=0, cpu_ack=0, busy=1, boot_done=0, clear pending=0.
REQ-032 SHALL, on reset mid-BOOT or mid-CLEAR, abort the operation and restart the full boot fill from address 0 after reset release.
REQ-033 SHALL start the first boot write (address 0) on the first MEMORY_CLK posedge after rst_n rises.

Structure
REQ-034 SHALL place VRAM_AW=10, VRAM_DEPTH=1024 and the state enum typedef in shared package vram_pkg.
REQ-035 SHALL implement the address counter (load 0, increment, terminal flag) as sub-module vram_fill_counter.

Verification
REQ-036 SHALL verify boot with BOOT_PATTERN=0: reset release -> 1024 writes of 8'h20 to addresses 0..1023, then boot_done=1 and busy=0.
REQ-037 SHALL verify a CPU write: cpu_req=1, ad=10'h005, din=8'h41 -> one write of 8'h41 to 5; cpu_ack held until req drops; no duplicate write.
REQ-038 SHALL verify clear: clear_req pulse with clear_char=8'h00 in IDLE -> 1024 writes of 8'h00, busy=1 throughout; a cpu_req in this window is acked only afterwards.
REQ-039 SHALL verify collisions: clear_req during BOOT -> CLEAR runs after boot; cpu_req and pending clear together -> CPU write first, then CLEAR.
REQ-040 SHALL verify reset mid-CLEAR at address 300 -> outputs reset at once; after release the boot fill restarts at address 0 with FILL_CHAR.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared VRAM geometry and the write-arbiter state encoding.
package vram_pkg;

   localparam int VRAM_AW    = 10;
   localparam int VRAM_DEPTH = 1024;

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      IDLE     = 3'd1,
      CPU_WR   = 3'd2,
      CPU_WAIT = 3'd3,
      CLEAR    = 3'd4
   } vram_state_e;

endpackage

// File: rtl/vram_fill_counter.sv
// Sweep address counter for boot fill and screen clear; wraps at the top of VRAM.
module vram_fill_counter
   import vram_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic               inc_i,
   output logic [VRAM_AW-1:0] cnt_o,
   output logic               term_o
);

   logic [VRAM_AW-1:0] cnt_q;
   logic [VRAM_AW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign term_o = (cnt_q == VRAM_AW'(VRAM_DEPTH - 1));

endmodule

// File: rtl/vram_write_arbiter.sv
// Single-port VRAM write arbiter: boot fill, CPU writes and full-screen clears.
module vram_write_arbiter
   import vram_pkg::*;
#(
   parameter logic [7:0] FILL_CHAR    = 8'h20,
   parameter bit         BOOT_PATTERN = 1'b0
) (
   input  logic               MEMORY_CLK,
   input  logic               rst_n,
   input  logic               cpu_req,
   input  logic [VRAM_AW-1:0] cpu_ad,
   input  logic [7:0]         cpu_din,
   output logic               cpu_ack,
   input  logic               clear_req,
   input  logic [7:0]         clear_char,
   output logic               v_cea,
   output logic [VRAM_AW-1:0] v_ada,
   output logic [7:0]         v_din,
   output logic               v_reseta,
   output logic               busy,
   output logic               boot_done,
   output vram_state_e        dbg_state
);

   // CPU handshake is four-phase: cpu_req is a level; the write happens once,
   // cpu_ack rises with it and stays high until cpu_req falls, then drops.

   vram_state_e        state_q;
   logic               pending_q;
   logic [7:0]         char_q;
   logic               v_cea_q;
   logic [VRAM_AW-1:0] v_ada_q;
   logic [7:0]         v_din_q;
   logic               cpu_ack_q;
   logic               busy_q;
   logic               boot_done_q;

   logic [VRAM_AW-1:0] cnt;
   logic               cnt_term;
   logic               cnt_load;
   logic               cnt_inc;
   logic               clr_hit;
   logic               pend_eff;
   logic [7:0]         char_eff;
   logic [7:0]         boot_data;

   assign cnt_load = (state_q == IDLE);
   assign cnt_inc  = (state_q == BOOT) || (state_q == CLEAR);

   vram_fill_counter u_fill_counter (
      .clk_i  (MEMORY_CLK),
      .rst_ni (rst_n),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .cnt_o  (cnt),
      .term_o (cnt_term)
   );

   // A clear pulse seen during CLEAR itself is dropped; elsewhere the newest pulse wins.
   assign clr_hit   = clear_req && (state_q != CLEAR);
   assign pend_eff  = pending_q || clr_hit;
   assign char_eff  = clr_hit ? clear_char : char_q;
   assign boot_data = BOOT_PATTERN ? cnt[7:0] : FILL_CHAR;

   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pending_q   <= 1'b0;
         char_q      <= 8'h00;
         v_cea_q     <= 1'b0;
         v_ada_q     <= '0;
         v_din_q     <= 8'h00;
         cpu_ack_q   <= 1'b0;
         busy_q      <= 1'b1;
         boot_done_q <= 1'b0;
      end else begin
         v_cea_q <= 1'b0;
         case (state_q)
            BOOT: begin
               v_cea_q   <= 1'b1;
               v_ada_q   <= cnt;
               v_din_q   <= boot_data;
               pending_q <= pend_eff;
               char_q    <= char_eff;
               if (cnt_term) begin
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               boot_done_q <= 1'b1;
               char_q      <= char_eff;
               if (cpu_req) begin
                  state_q   <= CPU_WR;
                  pending_q <= pend_eff;
                  busy_q    <= 1'b0;
               end else if (pend_eff) begin
                  state_q   <= CLEAR;
                  pending_q <= 1'b0;
                  busy_q    <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            CPU_WR: begin
               v_cea_q   <= 1'b1;
               v_ada_q   <= cpu_ad;
               v_din_q   <= cpu_din;
               cpu_ack_q <= 1'b1;
               pending_q <= pend_eff;
               char_q    <= char_eff;
               state_q   <= CPU_WAIT;
            end
            CPU_WAIT: begin
               pending_q <= pend_eff;
               char_q    <= char_eff;
               if (!cpu_req) begin
                  cpu_ack_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            CLEAR: begin
               v_cea_q <= 1'b1;
               v_ada_q <= cnt;
               v_din_q <= char_q;
               if (cnt_term) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   assign v_cea     = v_cea_q;
   assign v_ada     = v_ada_q;
   assign v_din     = v_din_q;
   assign v_reseta  = 1'b0;
   assign cpu_ack   = cpu_ack_q;
   assign busy      = busy_q;
   assign boot_done = boot_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: boot, CPU write, clear, collisions, reset mid-clear.
module tb_vram_write_arbiter;
   import vram_pkg::*;

   logic        MEMORY_CLK;
   logic        rst_n;
   logic        cpu_req;
   logic [9:0]  cpu_ad;
   logic [7:0]  cpu_din;
   logic        cpu_ack;
   logic        clear_req;
   logic [7:0]  clear_char;
   logic        v_cea;
   logic [9:0]  v_ada;
   logic [7:0]  v_din;
   logic        v_reseta;
   logic        busy;
   logic        boot_done;
   vram_state_e dbg_state;

   int n_assert;
   int n_fail;
   int wr_cnt;

   vram_write_arbiter #(
      .FILL_CHAR    (8'h20),
      .BOOT_PATTERN (1'b0)
   ) dut (
      .MEMORY_CLK (MEMORY_CLK),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_ad     (cpu_ad),
      .cpu_din    (cpu_din),
      .cpu_ack    (cpu_ack),
      .clear_req  (clear_req),
      .clear_char (clear_char),
      .v_cea      (v_cea),
      .v_ada      (v_ada),
      .v_din      (v_din),
      .v_reseta   (v_reseta),
      .busy       (busy),
      .boot_done  (boot_done),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial begin
      MEMORY_CLK = 1'b0;
      forever #5 MEMORY_CLK = ~MEMORY_CLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(posedge MEMORY_CLK) begin
      if (v_cea === 1'b1) wr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks n consecutive sweep writes of exp_char starting at address 0.
   task automatic fill_check(input string tag, input logic [7:0] exp_char, input int n);
      int errs;
      errs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge MEMORY_CLK);
         if (v_cea !== 1'b1 || v_ada !== 10'(i) || v_din !== exp_char ||
             busy !== 1'b1 || cpu_ack !== 1'b0) errs++;
      end
      chk({tag, "_bad_writes"}, 32'(errs), 32'd0);
      chk({tag, "_last_addr"}, 32'(v_ada), 32'(n - 1));
   endtask

   // Completes a CPU write whose cpu_req/cpu_ad/cpu_din are already driven.
   task automatic cpu_xact(input string tag, input logic [9:0] ad, input logic [7:0] din,
                           input int hold);
      bit found;
      int snap;
      int errs;
      found = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge MEMORY_CLK);
         if (cpu_ack === 1'b1) begin
            found = 1;
            break;
         end
      end
      chk({tag, "_ack_seen"}, 32'(found), 32'd1);
      chk({tag, "_wr_cea"}, 32'(v_cea), 32'd1);
      chk({tag, "_wr_ada"}, 32'(v_ada), 32'(ad));
      chk({tag, "_wr_din"}, 32'(v_din), 32'(din));
      snap = wr_cnt;
      errs = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge MEMORY_CLK);
         if (v_cea !== 1'b0 || cpu_ack !== 1'b1) errs++;
      end
      chk({tag, "_ack_hold"}, 32'(errs), 32'd0);
      cpu_req = 1'b0;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge MEMORY_CLK);
         if (cpu_ack === 1'b0) begin
            found = 1;
            break;
         end
      end
      chk({tag, "_ack_drop"}, 32'(found), 32'd1);
      chk({tag, "_one_write"}, 32'(wr_cnt - snap), 32'd1);
   endtask

   initial begin
      int snap;
      n_assert   = 0;
      n_fail     = 0;
      wr_cnt     = 0;
      rst_n      = 1'b0;
      cpu_req    = 1'b0;
      cpu_ad     = 10'h000;
      cpu_din    = 8'h00;
      clear_req  = 1'b0;
      clear_char = 8'h00;

      // reset state
      repeat (3) @(negedge MEMORY_CLK);
      chk("rst_v_cea", 32'(v_cea), 32'd0);
      chk("rst_v_ada", 32'(v_ada), 32'd0);
      chk("rst_v_din", 32'(v_din), 32'd0);
      chk("rst_v_reseta", 32'(v_reseta), 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_boot_done", 32'(boot_done), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(BOOT));

      // boot fill with FILL_CHAR
      rst_n = 1'b1;
      fill_check("boot", 8'h20, 1024);
      @(negedge MEMORY_CLK);
      chk("boot_end_cea", 32'(v_cea), 32'd0);
      chk("boot_end_done", 32'(boot_done), 32'd1);
      chk("boot_end_busy", 32'(busy), 32'd0);
      chk("boot_end_state", 32'(dbg_state), 32'(IDLE));

      // plain CPU write, req held for several cycles
      cpu_req = 1'b1;
      cpu_ad  = 10'h005;
      cpu_din = 8'h41;
      cpu_xact("cpu5", 10'h005, 8'h41, 5);

      // clear with 00; cpu_req and a second clear pulse arrive mid-clear
      clear_req  = 1'b1;
      clear_char = 8'h00;
      @(negedge MEMORY_CLK);
      clear_req = 1'b0;
      chk("clr0_busy_start", 32'(busy), 32'd1);
      chk("clr0_state", 32'(dbg_state), 32'(CLEAR));
      cpu_req = 1'b1;
      cpu_ad  = 10'h3ff;
      cpu_din = 8'h55;
      fork
         fill_check("clr0", 8'h00, 1024);
         begin
            repeat (200) @(negedge MEMORY_CLK);
            clear_req  = 1'b1;
            clear_char = 8'h11;
            @(negedge MEMORY_CLK);
            clear_req = 1'b0;
         end
      join
      @(negedge MEMORY_CLK);
      chk("clr0_end_busy", 32'(busy), 32'd0);
      chk("clr0_end_ack", 32'(cpu_ack), 32'd0);
      cpu_xact("cpu3ff", 10'h3ff, 8'h55, 2);
      snap = wr_cnt;
      repeat (5) @(negedge MEMORY_CLK);
      chk("ignored_clear_busy", 32'(busy), 32'd0);
      chk("ignored_clear_writes", 32'(wr_cnt - snap), 32'd0);

      // clear with C3, reset once address 300 is on the bus
      clear_req  = 1'b1;
      clear_char = 8'hc3;
      @(negedge MEMORY_CLK);
      clear_req = 1'b0;
      fill_check("clrc3", 8'hc3, 301);
      rst_n = 1'b0;
      #1;
      chk("midrst_v_cea", 32'(v_cea), 32'd0);
      chk("midrst_v_ada", 32'(v_ada), 32'd0);
      chk("midrst_v_din", 32'(v_din), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_boot_done", 32'(boot_done), 32'd0);
      chk("midrst_state", 32'(dbg_state), 32'(BOOT));
      repeat (2) @(negedge MEMORY_CLK);
      rst_n = 1'b1;

      // reboot; two clear pulses (last wins) and a stalled cpu_req during boot
      fork
         fill_check("boot2", 8'h20, 1024);
         begin
            repeat (500) @(negedge MEMORY_CLK);
            clear_req  = 1'b1;
            clear_char = 8'h2a;
            @(negedge MEMORY_CLK);
            clear_req = 1'b0;
            repeat (99) @(negedge MEMORY_CLK);
            clear_req  = 1'b1;
            clear_char = 8'h7e;
            @(negedge MEMORY_CLK);
            clear_req = 1'b0;
            repeat (99) @(negedge MEMORY_CLK);
            cpu_req = 1'b1;
            cpu_ad  = 10'h012;
            cpu_din = 8'h99;
         end
      join
      cpu_xact("cpu12", 10'h012, 8'h99, 2);
      @(negedge MEMORY_CLK);
      chk("coll_clear_busy", 32'(busy), 32'd1);
      chk("coll_clear_state", 32'(dbg_state), 32'(CLEAR));
      fill_check("clr7e", 8'h7e, 1024);
      @(negedge MEMORY_CLK);
      chk("clr7e_end_busy", 32'(busy), 32'd0);
      chk("clr7e_end_cea", 32'(v_cea), 32'd0);
      snap = wr_cnt;
      repeat (4) @(negedge MEMORY_CLK);
      chk("final_idle_state", 32'(dbg_state), 32'(IDLE));
      chk("final_no_writes", 32'(wr_cnt - snap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
